seq_multiplier: RTL and testbench

SEQ_MULTIPLIER -- requirements
Module: seq_multiplier

---
 rtl/seq_multiplier_pkg.sv | 21 ++
 rtl/seq_multiplier_pp_row.sv | 33 +++
 rtl/seq_multiplier.sv | 109 ++++++++++
 tb/tb_seq_multiplier.sv | 235 +++++++++++++++++++++++
 4 files changed

// File: rtl/seq_multiplier_pkg.sv
// Shared types and constants for the sequential Baugh-Wooley multiplier.
// Latency: n/a (package only).
// Backpressure: n/a (package only).
package seq_multiplier_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_BUSY = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  // Correction term for the modified Baugh-Wooley array: the inverted row
  // bits each stand in for a negative weight, and this constant restores the
  // missing -2^k terms. Only the low aw+bw bits are meaningful.
  function automatic logic [63:0] bw_corr(input int aw, input int bw);
    logic [63:0] r;
    r = (64'd1 << (aw - 1)) + (64'd1 << (bw - 1)) + (64'd1 << (aw + bw - 1));
    return r;
  endfunction

endpackage

// File: rtl/seq_multiplier_pp_row.sv
// One partial-product row: a AND b_bit, with Baugh-Wooley inversions in signed mode.
// Latency: combinational, zero cycles.
// Backpressure: none; purely combinational.
module pp_row #(
  parameter int AW = 7
) (
  input  logic [AW-1:0] a,
  input  logic          b_bit,
  input  logic          t,
  input  logic          last,
  output logic [AW:0]   row
);

  logic [AW-1:0] and_row;
  logic [AW-1:0] inv_mask;

  assign and_row = a & {AW{b_bit}};

  // Ordinary rows flip only the sign column; the last row flips all but it.
  always_comb begin
    inv_mask = '0;
    if (t) begin
      if (last) begin
        inv_mask = {1'b0, {(AW-1){1'b1}}};
      end else begin
        inv_mask = {1'b1, {(AW-1){1'b0}}};
      end
    end
  end

  assign row = {1'b0, and_row ^ inv_mask};

endmodule

// File: rtl/seq_multiplier.sv
// Sequential AW x BW multiplier, unsigned or two's-complement, one row per cycle.
// Latency: BW cycles in BUSY after the accept edge; product valid in the cycle after.
// Backpressure: result held in DONE until out_ready; new accept allowed on the hand-off edge.
module seq_multiplier
  import seq_multiplier_pkg::*;
#(
  parameter int AW = 7,
  parameter int BW = 6
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             t,
  input  logic [AW-1:0]    a,
  input  logic [BW-1:0]    b,
  input  logic             in_valid,
  output logic             in_ready,
  output logic [AW+BW-1:0] c,
  output logic             out_valid,
  input  logic             out_ready,
  output logic             busy
);

  localparam int CW = $clog2(BW + 1);
  localparam logic [63:0] CORR_FULL = bw_corr(AW, BW);
  localparam logic [AW+BW:0] CORR = CORR_FULL[AW+BW:0];

  state_t           state;
  logic [AW-1:0]    a_q;
  logic [BW-1:0]    b_q;
  logic             t_q;
  logic [AW+BW:0]   acc;
  logic [CW-1:0]    cnt;

  logic             accept;
  logic             last;
  logic             b_bit;
  logic [AW:0]      row;
  logic [AW+BW:0]   row_shift;
  logic [AW+BW:0]   sum;

  assign in_ready  = (state == ST_IDLE) || ((state == ST_DONE) && out_ready);
  assign accept    = in_valid && in_ready;
  assign busy      = (state == ST_BUSY);
  assign out_valid = (state == ST_DONE);
  assign last      = (cnt == CW'(BW - 1));

  // Pick the multiplier bit for the row being added this cycle.
  always_comb begin
    b_bit = 1'b0;
    for (int i = 0; i < BW; i++) begin
      if (cnt == CW'(i)) begin
        b_bit = b_q[i];
      end
    end
  end

  pp_row #(.AW(AW)) u_pp_row (
    .a     (a_q),
    .b_bit (b_bit),
    .t     (t_q),
    .last  (last),
    .row   (row)
  );

  assign row_shift = {{BW{1'b0}}, row} << cnt;
  assign sum       = acc + row_shift;

  // Control FSM, operand capture and row-by-row accumulation.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state <= ST_IDLE;
      a_q   <= '0;
      b_q   <= '0;
      t_q   <= 1'b0;
      acc   <= '0;
      cnt   <= '0;
      c     <= '0;
    end else begin
      case (state)
        ST_BUSY: begin
          acc <= sum;
          cnt <= cnt + CW'(1);
          if (last) begin
            c     <= sum[AW+BW-1:0];
            state <= ST_DONE;
          end
        end
        ST_DONE: begin
          if (out_ready && !in_valid) begin
            state <= ST_IDLE;
          end
        end
        default: begin
          state <= ST_IDLE;
        end
      endcase
      // An accept overrides the DONE -> IDLE move so the hand-off has no bubble.
      if (accept) begin
        a_q   <= a;
        b_q   <= b;
        t_q   <= t;
        acc   <= t ? CORR : '0;
        cnt   <= '0;
        state <= ST_BUSY;
      end
    end
  end

endmodule

// File: tb/tb_seq_multiplier.sv
module tb_seq_multiplier;

  localparam int AW = 7;
  localparam int BW = 6;
  localparam int PW = AW + BW;
  localparam int NSWEEP = 10000;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          t = 1'b0;
  logic [AW-1:0] a = '0;
  logic [BW-1:0] b = '0;
  logic          in_valid = 1'b0;
  logic          out_ready = 1'b0;
  logic          in_ready;
  logic [PW-1:0] c;
  logic          out_valid;
  logic          busy;

  int passed = 0;
  int total  = 0;
  int fails  = 0;

  seq_multiplier #(.AW(AW), .BW(BW)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .t         (t),
    .a         (a),
    .b         (b),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .c         (c),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  // Reference product from plain integer arithmetic.
  function automatic logic [PW-1:0] ref_mul(input logic tm, input logic [AW-1:0] x,
                                            input logic [BW-1:0] y);
    longint xv, yv, p;
    xv = tm ? longint'($signed(x)) : longint'(x);
    yv = tm ? longint'($signed(y)) : longint'(y);
    p  = xv * yv;
    return p[PW-1:0];
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else begin
      fails++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic scramble();
    a = AW'($urandom);
    b = BW'($urandom);
    t = 1'($urandom);
  endtask

  // One full transaction from IDLE: accept, busy timing, product, release.
  task automatic run_op(input string tag, input logic tm, input logic [AW-1:0] x,
                        input logic [BW-1:0] y, input logic [PW-1:0] exp, input bit junk);
    int n;
    int nb;
    t = tm; a = x; b = y; in_valid = 1'b1; out_ready = 1'b0;
    chk({tag, "_in_ready"}, 32'(in_ready), 32'd1);
    tick();
    in_valid = 1'b0;
    scramble();
    n = 0; nb = 0;
    while (!out_valid && n < 20) begin
      if (busy) nb++;
      if (junk && n < 3) begin
        in_valid = 1'b1;
        out_ready = 1'b1;
        scramble();
      end else begin
        in_valid = 1'b0;
        out_ready = 1'b0;
      end
      tick();
      n++;
    end
    in_valid = 1'b0;
    chk({tag, "_latency"}, 32'(n), 32'(BW));
    chk({tag, "_busy_cycles"}, 32'(nb), 32'(BW));
    chk({tag, "_c"}, 32'(c), 32'(exp));
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    chk({tag, "_released"}, 32'(out_valid), 32'd0);
    chk({tag, "_idle_ready"}, 32'(in_ready), 32'd1);
  endtask

  logic [PW-1:0] held_c;
  logic [PW-1:0] exp_q[$];
  logic          ct[8];
  logic [AW-1:0] ca[8];
  logic [BW-1:0] cb[8];

  initial begin
    int issued;
    int checked;
    int cyc;
    int seen;

    // Reset state.
    rst_n = 1'b0;
    tick();
    tick();
    chk("rst_in_ready", 32'(in_ready), 32'd1);
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_c", 32'(c), 32'd0);
    rst_n = 1'b1;
    tick();

    // Fixed corner products.
    run_op("neg_x_neg", 1'b1, 7'h40, 6'h20, 13'h0800, 1'b0);
    run_op("neg_x_pos", 1'b1, 7'h40, 6'h1F, 13'h1840, 1'b0);
    run_op("umax", 1'b0, 7'h7F, 6'h3F, 13'h1F41, 1'b0);
    run_op("zero_s", 1'b1, 7'h00, 6'h25, 13'h0000, 1'b0);
    // Operands and out_ready wiggled while busy must not disturb the result.
    run_op("ignore_busy", 1'b1, 7'h13, 6'h2B, ref_mul(1'b1, 7'h13, 6'h2B), 1'b1);

    // Stall in DONE, then back-to-back hand-off and accept.
    t = 1'b0; a = 7'h55; b = 6'h2A; in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    for (int i = 0; i < BW; i++) tick();
    chk("stall_enter_done", 32'(out_valid), 32'd1);
    held_c = c;
    chk("stall_c_value", 32'(held_c), 32'(ref_mul(1'b0, 7'h55, 6'h2A)));
    for (int i = 0; i < 5; i++) begin
      tick();
      chk("stall_c", 32'(c), 32'(held_c));
      chk("stall_out_valid", 32'(out_valid), 32'd1);
      chk("stall_in_ready", 32'(in_ready), 32'd0);
    end
    t = 1'b1; a = 7'h7F; b = 6'h3F; in_valid = 1'b1; out_ready = 1'b1;
    tick();
    in_valid = 1'b0; out_ready = 1'b0;
    scramble();
    chk("b2b_busy", 32'(busy), 32'd1);
    chk("b2b_out_valid", 32'(out_valid), 32'd0);
    for (int i = 0; i < BW; i++) tick();
    chk("b2b_done", 32'(out_valid), 32'd1);
    chk("b2b_c", 32'(c), 32'(ref_mul(1'b1, 7'h7F, 6'h3F)));
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;

    // Reset in the third BUSY cycle aborts the operation.
    t = 1'b0; a = 7'h3C; b = 6'h11; in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    tick();
    tick();
    chk("abort_busy_before", 32'(busy), 32'd1);
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    chk("abort_busy", 32'(busy), 32'd0);
    chk("abort_c", 32'(c), 32'd0);
    chk("abort_out_valid", 32'(out_valid), 32'd0);
    chk("abort_in_ready", 32'(in_ready), 32'd1);
    seen = 0;
    out_ready = 1'b1;
    for (int i = 0; i < 12; i++) begin
      tick();
      if (out_valid) seen++;
    end
    out_ready = 1'b0;
    chk("abort_no_result", 32'(seen), 32'd0);

    // Streaming random sweep with corners first.
    ct[0] = 1'b0; ca[0] = 7'h00; cb[0] = 6'h00;
    ct[1] = 1'b1; ca[1] = 7'h00; cb[1] = 6'h3F;
    ct[2] = 1'b1; ca[2] = 7'h40; cb[2] = 6'h00;
    ct[3] = 1'b1; ca[3] = 7'h40; cb[3] = 6'h20;
    ct[4] = 1'b1; ca[4] = 7'h3F; cb[4] = 6'h1F;
    ct[5] = 1'b0; ca[5] = 7'h7F; cb[5] = 6'h3F;
    ct[6] = 1'b1; ca[6] = 7'h7F; cb[6] = 6'h3F;
    ct[7] = 1'b0; ca[7] = 7'h00; cb[7] = 6'h2D;
    issued = 0; checked = 0; cyc = 0;
    t = ct[0]; a = ca[0]; b = cb[0];
    in_valid = 1'b1; out_ready = 1'b1;
    while ((issued < NSWEEP || exp_q.size() != 0) && cyc < 90000) begin
      logic acc_now;
      if (out_valid && out_ready) begin
        if (exp_q.size() != 0) begin
          chk("sweep_c", 32'(c), 32'(exp_q.pop_front()));
          checked++;
        end
      end
      acc_now = in_valid && in_ready;
      if (acc_now) begin
        exp_q.push_back(ref_mul(t, a, b));
        issued++;
      end
      tick();
      cyc++;
      if (acc_now) begin
        if (issued >= NSWEEP) begin
          in_valid = 1'b0;
          scramble();
        end else if (issued < 8) begin
          t = ct[issued]; a = ca[issued]; b = cb[issued];
        end else begin
          scramble();
          if ($urandom_range(9) == 0) a = '0;
          if ($urandom_range(9) == 0) b = '0;
        end
      end
    end
    in_valid = 1'b0; out_ready = 1'b0;
    chk("sweep_checked", 32'(checked), 32'(NSWEEP));
    tick();
    chk("sweep_idle", 32'(in_ready), 32'd1);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
